// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcode constants and datapath select encodings.
package multi_cycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  localparam logic [1:0] PC_SRC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_SRC_PLUSIMM = 2'b01;
  localparam logic [1:0] PC_SRC_ALU     = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MDR = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // ECALL is handled separately in ID, so it is not part of this set.
  function automatic logic is_exec_opcode(input logic [6:0] op);
    return (op == OP_ARITHMETIC) || (op == OP_ARITHMETIC_IMM) ||
           (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for mem_ready and flags
// when the configured limit is reached (limit 0 never expires).
module mcu_wait_timer #(
  parameter int unsigned WAIT_CNT_W     = 8,
  parameter int unsigned MEM_WAIT_LIMIT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  if (MEM_WAIT_LIMIT >= (64'd1 << WAIT_CNT_W)) begin : g_bad_limit
    $error("MEM_WAIT_LIMIT must be below 2**WAIT_CNT_W");
  end

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_WAIT_LIMIT != 0) &&
                     (cnt_q == WAIT_CNT_W'(MEM_WAIT_LIMIT));

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM (INIT/IF/ID/EX/MEM/WB/HALT) driving the shared
// memory port and datapath selects. Define MCU_PERF_CNT_EN for cycle/instret counters.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_WAIT_LIMIT = 0,
  parameter int unsigned WAIT_CNT_W     = 8,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic       mem_timeout
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e state_q, state_d;
  logic   halted_q, mem_timeout_q;
  logic   timeout_evt;
  logic   wait_expired;

  mcu_wait_timer #(
    .WAIT_CNT_W    (WAIT_CNT_W),
    .MEM_WAIT_LIMIT(MEM_WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (state_d != state_q),
    .inc_i    (((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    pc_write    = 1'b0;
    pc_source   = PC_SRC_PLUS4;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = WB_SEL_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = ALU_B_RS2;
    alu_op      = ALU_OP_ADD;
    illegal     = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_IF;

      ST_IF: begin
        // A ready on the limit cycle still completes the fetch.
        if (!mem_ready && wait_expired) begin
          timeout_evt = 1'b1;
          state_d     = ST_HALT;
        end else begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          if (mem_ready) state_d = ST_ID;
        end
      end

      ST_ID: begin
        if (opcode == OP_ECALL) begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_IF;
          end
        end else if (!is_exec_opcode(opcode)) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end

      ST_EX: begin
        state_d = ST_WB;
        case (opcode)
          OP_ARITHMETIC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_RS2;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_ARITHMETIC_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
            state_d   = ST_MEM;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
          end
          OP_JAL: ;
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_RS2;
            alu_op    = ALU_OP_BRANCH;
            pc_write  = 1'b1;
            pc_source = bcond ? PC_SRC_PLUSIMM : PC_SRC_PLUS4;
            state_d   = ST_IF;
          end
          default: state_d = ST_IF;
        endcase
      end

      ST_MEM: begin
        if (!mem_ready && wait_expired) begin
          timeout_evt = 1'b1;
          state_d     = ST_HALT;
        end else begin
          iord = 1'b1;
          if (opcode == OP_LOAD) begin
            mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end else if (opcode == OP_STORE) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              pc_write = 1'b1;
              state_d  = ST_IF;
            end
          end else begin
            state_d = ST_IF;
          end
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_IF;
        case (opcode)
          OP_LOAD: wb_sel = WB_SEL_MDR;
          OP_JAL: begin
            wb_sel    = WB_SEL_PC4;
            pc_source = PC_SRC_PLUSIMM;
          end
          OP_JALR: begin
            wb_sel    = WB_SEL_PC4;
            pc_source = PC_SRC_ALU;
          end
          default: wb_sel = WB_SEL_ALU;
        endcase
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_q | (state_d == ST_HALT);
      mem_timeout_q <= mem_timeout_q | timeout_evt;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;

`ifdef MCU_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if ((state_q != ST_INIT) && (state_q != ST_HALT)) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end
      if (pc_write && !illegal) begin
        instret_cnt_q <= instret_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: per-cycle output vectors are
// compared against hand-written expectations, one task per scenario.
module tb_multi_cycle_control_unit;

  logic       clk;
  logic       reset_n;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_req;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       halted;
  logic       illegal;
  logic       mem_timeout;

  int checks = 0;
  int errors = 0;

  multi_cycle_control_unit #(
    .MEM_WAIT_LIMIT(4),
    .WAIT_CNT_W    (8),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .bcond      (bcond),
    .halt_req   (halt_req),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .halted     (halted),
    .illegal    (illegal),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write,pc_source,iord,mem_read,mem_write,ir_write,reg_write,wb_sel,
  //  alu_src_a,alu_src_b,alu_op,halted,illegal,mem_timeout}
  logic [17:0] obs;
  assign obs = {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, halted, illegal, mem_timeout};

  function automatic logic [17:0] ov(input logic pcw, input logic [1:0] pcs,
                                     input logic io, input logic mr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] wbs,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic h,
                                     input logic ill, input logic to);
    return {pcw, pcs, io, mr, mw, irw, rw, wbs, asa, asb, aop, h, ill, to};
  endfunction

  localparam logic [17:0] V_ZERO = '0;
  logic [17:0] v_if_rdy, v_if_wait, v_ex_arith, v_ex_imm, v_wb_alu, v_ex_mem, v_mem_ld,
               v_wb_ld, v_mem_st, v_mem_st_done, v_ex_br_t, v_ex_br_n, v_wb_jal,
               v_wb_jalr, v_id_ill, v_id_ecall, v_halt, v_halt_to;

  initial begin
    v_if_rdy      = ov(0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_if_wait     = ov(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_ex_arith    = ov(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0);
    v_ex_imm      = ov(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b10, 0, 0, 0);
    v_wb_alu      = ov(1, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_ex_mem      = ov(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0);
    v_mem_ld      = ov(0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_wb_ld       = ov(1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    v_mem_st      = ov(0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_mem_st_done = ov(1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_ex_br_t     = ov(1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 0, 0);
    v_ex_br_n     = ov(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 0, 0);
    v_wb_jal      = ov(1, 2'b01, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
    v_wb_jalr     = ov(1, 2'b10, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
    v_id_ill      = ov(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
    v_id_ecall    = ov(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    v_halt        = ov(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    v_halt_to     = ov(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1);
  end

  // Each step starts on a falling edge: drive inputs, settle, compare, move on.
  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== V_ZERO) begin
        $display("FAIL reset step %0d: got %b expected %b", i, obs, V_ZERO);
        errors++;
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    $display("reset: held 3 cycles, released");
  endtask

  task automatic test_add();
    logic [17:0] e[5];
    e = '{V_ZERO, v_if_rdy, V_ZERO, v_ex_arith, v_wb_alu};
    opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL add step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("add: INIT,IF,ID,EX,WB checked");
  endtask

  task automatic test_addi();
    logic [17:0] e[4];
    e = '{v_if_rdy, V_ZERO, v_ex_imm, v_wb_alu};
    opcode = 7'b0010011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL addi step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("addi: 4 cycles checked");
  endtask

  task automatic test_load_wait();
    logic [17:0] e[7];
    logic        r[7];
    e = '{v_if_rdy, V_ZERO, v_ex_mem, v_mem_ld, v_mem_ld, v_mem_ld, v_wb_ld};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL load_wait step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("load: MEM held 3 cycles, 7 cycles total");
  endtask

  task automatic test_store_wait();
    logic [17:0] e[5];
    logic        r[5];
    e = '{v_if_rdy, V_ZERO, v_ex_mem, v_mem_st, v_mem_st_done};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL store_wait step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("store: mem_write held across one wait cycle");
  endtask

  task automatic test_branch();
    logic [17:0] e[6];
    logic        b[6];
    e = '{v_if_rdy, V_ZERO, v_ex_br_t, v_if_rdy, V_ZERO, v_ex_br_n};
    b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    opcode = 7'b1100011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      bcond     = b[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL branch step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    bcond = 1'b0;
    $display("branch: taken then not taken, 3 cycles each");
  endtask

  task automatic test_jumps();
    logic [17:0] e[8];
    logic [6:0]  op[8];
    e  = '{v_if_rdy, V_ZERO, V_ZERO, v_wb_jal, v_if_rdy, V_ZERO, v_ex_mem, v_wb_jalr};
    op = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111,
           7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111};
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b1;
      opcode    = op[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL jumps step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("jal/jalr: write-back selects checked");
  endtask

  task automatic test_id_exits();
    logic [17:0] e[4];
    logic [6:0]  op[4];
    e  = '{v_if_rdy, v_id_ill, v_if_rdy, v_id_ecall};
    op = '{7'b1111111, 7'b1111111, 7'b1110011, 7'b1110011};
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      opcode    = op[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL id_exits step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("illegal opcode and ecall without halt: 2 cycles each");
  endtask

  task automatic test_limit_ready_wins();
    logic [17:0] e[8];
    logic        r[8];
    e = '{v_if_wait, v_if_wait, v_if_wait, v_if_wait, v_if_rdy, V_ZERO, v_ex_arith, v_wb_alu};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 7'b0110011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL limit_ready step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    $display("fetch: ready on the limit cycle completes normally");
  endtask

  task automatic test_timeout();
    logic [17:0] e[15];
    e = '{v_if_wait, v_if_wait, v_if_wait, v_if_wait, V_ZERO,
          v_halt_to, v_halt_to, v_halt_to, v_halt_to, v_halt_to,
          v_halt_to, v_halt_to, v_halt_to, v_halt_to, v_halt_to};
    opcode = 7'b0110011;
    for (int i = 0; i < 15; i++) begin
      mem_ready = (i >= 5);
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL timeout step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_ZERO) begin
      $display("FAIL timeout_async_clear: got %b expected %b", obs, V_ZERO);
      errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("fetch timeout: sticky flags held 10 cycles, cleared by reset");
  endtask

  task automatic test_ecall_halt();
    logic [17:0] e[6];
    e = '{V_ZERO, v_if_rdy, V_ZERO, v_halt, v_halt, v_halt};
    opcode   = 7'b1110011;
    halt_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL ecall_halt step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      @(negedge clk);
    end
    halt_req = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    $display("ecall with halt_req: HALT from ID");
  endtask

  task automatic test_reset_mid_mem();
    logic [17:0] e[6];
    logic        r[6];
    e = '{V_ZERO, v_if_rdy, V_ZERO, v_ex_mem, v_mem_ld, V_ZERO};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL reset_mid_mem step %0d: got %b expected %b", i, obs, e[i]);
        errors++;
      end
      if (i < 4) @(negedge clk);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== e[5]) begin
      $display("FAIL reset_mid_mem async: got %b expected %b", obs, e[5]);
      errors++;
    end
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_ZERO) begin
      $display("FAIL reset_mid_mem init: got %b expected %b", obs, V_ZERO);
      errors++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== v_if_rdy) begin
      $display("FAIL reset_mid_mem restart: got %b expected %b", obs, v_if_rdy);
      errors++;
    end
    $display("reset mid-MEM: strobes dropped asynchronously, restart at INIT");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    opcode    = 7'b0000000;
    bcond     = 1'b0;
    halt_req  = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_addi();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_jumps();
    test_id_exits();
    test_limit_ready_wins();
    test_timeout();
    test_ecall_halt();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Next-generation RV32I control unit for the multi-cycle datapath.
- Replaces the purely combinational opcode decode with a Moore/Mealy FSM: fetch, decode, execute, memory and write-back phases.
- Drives one shared memory port with a ready handshake, plus the datapath mux selects and write strobes.
- Sits between the instruction register opcode field and the datapath muxes, PC register and register file.

Parameters:
- MEM_WAIT_LIMIT, 0: max cycles waiting for mem_ready in IF/MEM; 0 = unlimited.
- WAIT_CNT_W, 8: width of the wait counter; MEM_WAIT_LIMIT must be < 2**WAIT_CNT_W.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction[6:0] from the IR.
- bcond  in  1  branch-condition result from the ALU.
- halt_req  in  1  ECALL with x17==10; sampled in ID.
- mem_ready  in  1  shared memory completes the access this cycle.
- pc_write  out  1  PC register load strobe.
- pc_source  out  2  00 pc+4, 01 pc+imm, 10 ALU result & ~1 (JALR).
- iord  out  1  memory address: 0 PC, 1 ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load strobe.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  00 ALU, 01 MDR, 10 pc+4.
- alu_src_a  out  1  0 PC, 1 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
- halted  out  1  sticky; set on entering HALT.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- mem_timeout  out  1  sticky; set when the wait limit is exceeded.

Behaviour:
- States: INIT, IF, ID, EX, MEM, WB, HALT. Outputs default to 0 unless listed for a state.
- Reset:
  - Asynchronous assertion forces state=INIT, counters=0 and halted/mem_timeout=0 immediately, mid-access included.
  - INIT drives all outputs 0; INIT->IF on the next edge after reset release.
- IF: mem_read=1, iord=0. ir_write=mem_ready (Mealy). mem_ready -> ID, else stay.
- ID: decode only, no strobes.
  - ECALL with halt_req -> HALT.
  - ECALL without halt_req -> pc_write=1, pc_source=00, then IF.
  - Unknown opcode -> illegal=1, pc_write=1, pc_source=00, then IF.
  - All other opcodes -> EX.
- EX, by opcode:
  - ARITHMETIC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ARITHMETIC_IMM: alu_src_a=1, alu_src_b=01, alu_op=10.
  - LOAD and STORE: alu_src_a=1, alu_src_b=01, alu_op=00.
  - JALR: alu_src_a=1, alu_src_b=01, alu_op=00.
  - JAL: no ALU use.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1, pc_source = bcond ? 01 : 00; then IF (3 cycles total).
  - LOAD/STORE -> MEM; all others -> WB.
- MEM: iord=1.
  - LOAD: mem_read=1.
  - STORE: mem_write=1, held until mem_ready.
  - No mem_ready -> stay.
  - LOAD with mem_ready -> WB.
  - STORE with mem_ready -> pc_write=1, pc_source=00, then IF.
- WB: reg_write=1, pc_write=1, then IF.
  - LOAD: wb_sel=01, pc_source=00.
  - ARITHMETIC/ARITHMETIC_IMM: wb_sel=00, pc_source=00.
  - JAL: wb_sel=10, pc_source=01.
  - JALR: wb_sel=10, pc_source=10.
- Latencies with mem_ready always 1:
  - R/I-type 4, LOAD 5, STORE 4, BRANCH 3, JAL/JALR 4 cycles.
- Wait counter:
  - Clears on entry to IF/MEM; increments each cycle there without mem_ready.
  - If MEM_WAIT_LIMIT!=0 and counter==MEM_WAIT_LIMIT while mem_ready is still 0: set mem_timeout, go to HALT, no strobes that cycle.
  - mem_ready on the limit cycle wins over timeout.
- HALT: absorbing, all strobes 0, halted=1; exits only on reset.
- Opcode is sampled combinationally; the IR is stable from ID through the final state.

Optional Feature:
- Macro MCU_PERF_CNT_EN.
- Defined:
  - Extra outputs cycle_cnt[CNT_W] (increments every cycle outside INIT/HALT) and instret_cnt[CNT_W] (increments on each pc_write outside the illegal path).
  - Both wrap modulo 2**CNT_W and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants (the existing opcode defines);
  - pc_source, wb_sel, alu_src_b and alu_op encodings.
- One sub-module, mcu_wait_timer: counter plus limit compare, parameterised by WAIT_CNT_W and MEM_WAIT_LIMIT.

Test Plan:
- Reset held 3 cycles, then ADD (0110011) with mem_ready=1 -> INIT,IF,ID,EX,WB; reg_write=1 and wb_sel=00 only in WB; pc_write once.
- LOAD with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, mem_read=1 throughout, WB wb_sel=01; total 7 cycles.
- BRANCH with bcond=1, then bcond=0 -> 3 cycles each; pc_source=01, then 00 in EX.
- JALR -> WB has wb_sel=10, pc_source=10, reg_write=1.
- MEM_WAIT_LIMIT=4, mem_ready stuck 0 in IF -> mem_timeout and halted set after 4 wait cycles; state stays HALT for 10 cycles.
- ECALL with halt_req=1 -> HALT from ID; reset_n pulsed low mid-MEM -> all strobes drop asynchronously, restart at INIT.
